if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 10 +
 rtl/if_stage_if.sv | 39 +++
 rtl/if_fifo.sv | 80 ++++++++
 rtl/if_stage.sv | 76 +++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants: default widths, reset fetch address and the NOP encoding.
package if_stage_pkg;

    localparam int unsigned IF_ADDR_W_DEF = 32;
    localparam int unsigned IF_DATA_W_DEF = 32;
    localparam logic [31:0] IF_RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;
    localparam int unsigned IF_PC_STEP = 4;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM fetch port, execute redirect, and the valid/ready hand-off to decode.
interface if_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] if_rom_pc_o;
    logic [DATA_W-1:0] if_rom_inst_i;
    logic              if_jump_en_i;
    logic [ADDR_W-1:0] if_jump_addr_i;
    logic              if_id_valid_o;
    logic              if_id_ready_i;
    logic [ADDR_W-1:0] if_id_pc_o;
    logic [DATA_W-1:0] if_id_inst_o;
    logic              if_misalign_o;

    modport master (
        output if_rom_pc_o,
        input  if_rom_inst_i,
        input  if_jump_en_i,
        input  if_jump_addr_i,
        output if_id_valid_o,
        input  if_id_ready_i,
        output if_id_pc_o,
        output if_id_inst_o,
        output if_misalign_o
    );

    modport slave (
        input  if_rom_pc_o,
        output if_rom_inst_i,
        output if_jump_en_i,
        output if_jump_addr_i,
        input  if_id_valid_o,
        output if_id_ready_i,
        input  if_id_pc_o,
        input  if_id_inst_o,
        input  if_misalign_o
    );
endinterface

// File: rtl/if_fifo.sv
// Two-entry {pc, inst} buffer with the head held in entry 0 so outputs come straight from flops.
// Latency: push visible at head the next cycle when empty. Backpressure: push is dropped when full without a same-cycle pop.
// Clear empties the buffer in one cycle; reset also loads the head with a NOP.
module if_fifo
    import if_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_inst,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_inst,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [ADDR_W-1:0] pc0, pc1;
    logic [DATA_W-1:0] inst0, inst1;
    logic              pop_q;
    logic              push_q;

    assign full   = (count == 2'd2);
    assign empty  = (count == 2'd0);
    assign pop_q  = pop && !empty;
    assign push_q = push && (!full || pop_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            pc0   <= '0;
            inst0 <= DATA_W'(IF_NOP_INST);
            pc1   <= '0;
            inst1 <= DATA_W'(IF_NOP_INST);
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({push_q, pop_q})
                2'b10: begin
                    if (count == 2'd0) begin
                        pc0   <= push_pc;
                        inst0 <= push_inst;
                    end else begin
                        pc1   <= push_pc;
                        inst1 <= push_inst;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    pc0   <= pc1;
                    inst0 <= inst1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged: with one entry the new word becomes head, with two it shifts in behind.
                    if (count == 2'd1) begin
                        pc0   <= push_pc;
                        inst0 <= push_inst;
                    end else begin
                        pc0   <= pc1;
                        inst0 <= inst1;
                        pc1   <= push_pc;
                        inst1 <= push_inst;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_pc   = pc0;
    assign head_inst = inst0;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register drives a combinational ROM; fetched words queue in a 2-entry buffer toward decode.
// Latency: fetch-to-valid 1 cycle; redirect-to-valid 2 cycles. Backpressure: PC and buffer hold while full and decode not ready.
// Build option IF_MISALIGN_CHK_EN flags redirects whose target has nonzero low bits.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC_DEF,
    parameter int unsigned ADDR_W   = IF_ADDR_W_DEF,
    parameter int unsigned DATA_W   = IF_DATA_W_DEF
) (
    input  logic clk,
    input  logic rst,
    if_stage_if.master bus
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] jump_tgt;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [1:0]        count;

    assign jump_tgt = bus.if_jump_addr_i & ~ADDR_W'(3);
    assign pop      = bus.if_id_valid_o && bus.if_id_ready_i;
    // A redirect kills the word currently on the ROM bus.
    assign push     = !bus.if_jump_en_i && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (bus.if_jump_en_i) begin
            pc <= jump_tgt;
        end else if (push) begin
            pc <= pc + ADDR_W'(IF_PC_STEP);
        end
    end

    if_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.if_jump_en_i),
        .push      (push),
        .pop       (pop),
        .push_pc   (pc),
        .push_inst (bus.if_rom_inst_i),
        .head_pc   (bus.if_id_pc_o),
        .head_inst (bus.if_id_inst_o),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign bus.if_rom_pc_o   = pc;
    assign bus.if_id_valid_o = !empty;

`ifdef IF_MISALIGN_CHK_EN
    logic misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= bus.if_jump_en_i && (bus.if_jump_addr_i[1:0] != 2'b00);
        end
    end

    assign bus.if_misalign_o = misalign;
`else
    assign bus.if_misalign_o = 1'b0;
`endif

endmodule
